// File: rtl/grf_scoreboard_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : grf_scoreboard_if
// Description : D-stage <-> GRF scoreboard bundle. Carries the destination
//               issue of the D-stage instruction, the two source-operand
//               reads, the external stall request, and the scoreboard's
//               stall / forward-select / busy answers.
//               master : pipeline D-stage (drives issue/read, receives stall)
//               slave  : scoreboard
// Revision    : 1.0  initial release
// ============================================================================
interface grf_scoreboard_if #(
  parameter int AW = 5,   // register address width
  parameter int TW = 2,   // Tnew/Tuse width
  parameter int SW = 2    // forward-select (stage) width
) ();
  logic          issue_valid;
  logic [AW-1:0] issue_a3;
  logic [TW-1:0] issue_tnew;
  logic          rd_en1;
  logic [AW-1:0] rd_a1;
  logic [TW-1:0] rd_tuse1;
  logic          rd_en2;
  logic [AW-1:0] rd_a2;
  logic [TW-1:0] rd_tuse2;
  logic          ext_stall;
  logic          stall;
  logic [SW-1:0] fwd_sel1;
  logic [SW-1:0] fwd_sel2;
  logic          busy;

  modport master (
    output issue_valid, issue_a3, issue_tnew,
    output rd_en1, rd_a1, rd_tuse1,
    output rd_en2, rd_a2, rd_tuse2,
    output ext_stall,
    input  stall, fwd_sel1, fwd_sel2, busy
  );

  modport slave (
    input  issue_valid, issue_a3, issue_tnew,
    input  rd_en1, rd_a1, rd_tuse1,
    input  rd_en2, rd_a2, rd_tuse2,
    input  ext_stall,
    output stall, fwd_sel1, fwd_sel2, busy
  );
endinterface
`default_nettype wire

// File: rtl/grf_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : grf_scoreboard
// Description : Tracks in-flight GRF writes of the E/M/W stages. For each
//               architectural register it keeps the stage of the youngest
//               pending writer (age) and the cycles until its result becomes
//               forwardable (tnew). D-stage reads are checked against that
//               state to produce the D-stage stall and forward selects.
// Ports       : clk    - clock
//               reset  - synchronous, active-high reset
//               sb     - scoreboard bundle (slave side): issue_*, rd_*,
//                        ext_stall in; stall, fwd_sel1/2, busy out
// Revision    : 1.0  initial release
// ============================================================================
module grf_scoreboard #(
  parameter int NREG  = 32,  // architectural registers, $0 is hard-wired zero
  parameter int DEPTH = 3,   // cycles from E entry to GRF write
  parameter int TW    = 2    // Tnew/Tuse width
) (
  input  logic             clk,
  input  logic             reset,
  grf_scoreboard_if.slave  sb
);

  localparam int AW = $clog2(NREG);
  localparam int GW = $clog2(DEPTH + 1);
  localparam logic [GW-1:0] c_age_last = GW'(DEPTH);

  // Flattened per-register view; entry 0 is constant zero so reads of $0
  // never hazard and never forward.
  logic [GW-1:0] w_age  [NREG];
  logic [TW-1:0] w_tnew [NREG];

  logic w_haz1;
  logic w_haz2;
  logic w_stall;
  logic w_iss;
  logic w_busy;

  assign w_age[0]  = '0;
  assign w_tnew[0] = '0;

  // Hazards only look at registered state, never at the instruction issuing
  // this cycle, so stall has no combinational path from issue_*.
  always_comb begin
    w_haz1 = sb.rd_en1 && (sb.rd_a1 != '0) && (w_age[sb.rd_a1] != '0)
             && (w_tnew[sb.rd_a1] > sb.rd_tuse1);
    w_haz2 = sb.rd_en2 && (sb.rd_a2 != '0) && (w_age[sb.rd_a2] != '0)
             && (w_tnew[sb.rd_a2] > sb.rd_tuse2);
    w_stall = !reset && (w_haz1 || w_haz2 || sb.ext_stall);
    // A stalled D-stage turns into a bubble in E: nothing is issued.
    w_iss   = sb.issue_valid && !w_stall && (sb.issue_a3 != '0);
  end

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [GW-1:0] r_age;
    logic [TW-1:0] r_tnew;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_age  <= '0;
        r_tnew <= '0;
      end else if (w_iss && (sb.issue_a3 == AW'(r))) begin
        // Youngest writer takes over the entry; the older one still reaches
        // the GRF first, so dropping its tracking loses nothing.
        r_age  <= GW'(1);
        r_tnew <= sb.issue_tnew;
      end else if (r_age != '0) begin
        r_age  <= (r_age == c_age_last) ? '0 : r_age + GW'(1);
        r_tnew <= (r_tnew == '0) ? '0 : r_tnew - TW'(1);
      end
    end

    assign w_age[r]  = r_age;
    assign w_tnew[r] = r_tnew;
  end

  always_comb begin
    w_busy = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      w_busy = w_busy | (w_age[r] != '0);
    end
  end

  // age doubles as the forward source: 1=E, 2=M, 3=W, 0=GRF.
  assign sb.stall    = w_stall;
  assign sb.fwd_sel1 = reset ? '0 : w_age[sb.rd_a1];
  assign sb.fwd_sel2 = reset ? '0 : w_age[sb.rd_a2];
  assign sb.busy     = !reset && w_busy;

endmodule
`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_grf_scoreboard
// Description : Testbench for grf_scoreboard. Directed scenarios plus a
//               randomized run against a pipeline-level reference model
//               (explicit E/M/W slots holding the instruction that occupies
//               each stage).
// Revision    : 1.0  initial release
// ============================================================================
module tb_grf_scoreboard;

  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int TW    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_scoreboard_if #(.AW(5), .TW(TW), .SW(2)) sb_if ();

  grf_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference pipeline: slot 1=E, 2=M, 3=W; each holds the destination and
  // the Tnew it was issued with.
  bit         m_v [1:DEPTH];
  logic [4:0] m_r [1:DEPTH];
  logic [1:0] m_t [1:DEPTH];

  function automatic int m_stage(logic [4:0] a);
    if (a == 5'd0) return 0;
    for (int s = 1; s <= DEPTH; s++)
      if (m_v[s] && m_r[s] == a) return s;
    return 0;
  endfunction

  function automatic int m_rem(logic [4:0] a);
    int s;
    int t;
    s = m_stage(a);
    if (s == 0) return 0;
    t = int'(m_t[s]) - (s - 1);
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_haz(logic en, logic [4:0] a, logic [1:0] tu);
    return en && (m_stage(a) != 0) && (m_rem(a) > int'(tu));
  endfunction

  function automatic bit m_stall();
    if (reset) return 1'b0;
    return m_haz(sb_if.rd_en1, sb_if.rd_a1, sb_if.rd_tuse1) ||
           m_haz(sb_if.rd_en2, sb_if.rd_a2, sb_if.rd_tuse2) ||
           sb_if.ext_stall;
  endfunction

  function automatic logic [5:0] m_expect();
    bit any;
    any = 1'b0;
    if (reset) return 6'd0;
    for (int s = 1; s <= DEPTH; s++) any = any | m_v[s];
    return {m_stall(), 2'(m_stage(sb_if.rd_a1)), 2'(m_stage(sb_if.rd_a2)), any};
  endfunction

  // {stall, fwd_sel1, fwd_sel2, busy}
  function automatic logic [5:0] obs();
    return {sb_if.stall, sb_if.fwd_sel1, sb_if.fwd_sel2, sb_if.busy};
  endfunction

  task automatic idle();
    sb_if.issue_valid = 1'b0; sb_if.issue_a3 = '0; sb_if.issue_tnew = '0;
    sb_if.rd_en1 = 1'b0; sb_if.rd_a1 = '0; sb_if.rd_tuse1 = '0;
    sb_if.rd_en2 = 1'b0; sb_if.rd_a2 = '0; sb_if.rd_tuse2 = '0;
    sb_if.ext_stall = 1'b0;
  endtask

  // One clock: decide issue from the model, advance model at the edge, and
  // return on the next falling edge ready for new stimulus.
  task automatic tick();
    bit iss;
    if (sb_if.issue_valid)
      assert (int'(sb_if.issue_tnew) <= DEPTH - 1) else $error("illegal issue_tnew");
    iss = !reset && sb_if.issue_valid && !m_stall() && (sb_if.issue_a3 != 5'd0);
    @(posedge clk);
    if (reset) begin
      for (int s = 1; s <= DEPTH; s++) m_v[s] = 1'b0;
    end else begin
      for (int s = DEPTH; s >= 2; s--) begin
        m_v[s] = m_v[s-1]; m_r[s] = m_r[s-1]; m_t[s] = m_t[s-1];
      end
      m_v[1] = iss; m_r[1] = sb_if.issue_a3; m_t[1] = sb_if.issue_tnew;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    sb_if.rd_en1 = 1'b1; sb_if.rd_a1 = 5'd4; sb_if.ext_stall = 1'b1;
    #1; checks++;
    if (obs() !== 6'b000000) begin errors++; $display("FAIL reset_hold got=%b exp=%b", obs(), 6'b000000); end
    tick(); reset = 1'b0; idle();
    #1; checks++;
    if (obs() !== 6'b000000) begin errors++; $display("FAIL post_reset got=%b exp=%b", obs(), 6'b000000); end
  endtask

  task automatic test_load_use();
    do_reset();
    sb_if.issue_valid = 1'b1; sb_if.issue_a3 = 5'd5; sb_if.issue_tnew = 2'd2;
    tick();
    idle(); sb_if.rd_en1 = 1'b1; sb_if.rd_a1 = 5'd5; sb_if.rd_tuse1 = 2'd0;
    #1; checks++;
    if (obs() !== 6'b101001) begin errors++; $display("FAIL load_use_e got=%b exp=%b", obs(), 6'b101001); end
    tick(); #1; checks++;
    if (obs() !== 6'b110001) begin errors++; $display("FAIL load_use_m got=%b exp=%b", obs(), 6'b110001); end
    tick(); #1; checks++;
    if (obs() !== 6'b011001) begin errors++; $display("FAIL load_use_w got=%b exp=%b", obs(), 6'b011001); end
    tick(); #1; checks++;
    if (obs() !== 6'b000000) begin errors++; $display("FAIL load_use_clear got=%b exp=%b", obs(), 6'b000000); end
  endtask

  task automatic test_alu_alu();
    do_reset();
    sb_if.issue_valid = 1'b1; sb_if.issue_a3 = 5'd3; sb_if.issue_tnew = 2'd1;
    tick();
    idle(); sb_if.rd_en1 = 1'b1; sb_if.rd_a1 = 5'd3; sb_if.rd_tuse1 = 2'd1;
    #1; checks++;
    if (obs() !== 6'b001001) begin errors++; $display("FAIL alu_alu_e got=%b exp=%b", obs(), 6'b001001); end
    tick(); #1; checks++;
    if (obs() !== 6'b010001) begin errors++; $display("FAIL alu_alu_m got=%b exp=%b", obs(), 6'b010001); end
  endtask

  task automatic test_reg0();
    do_reset();
    sb_if.issue_valid = 1'b1; sb_if.issue_a3 = 5'd0; sb_if.issue_tnew = 2'd2;
    tick();
    idle();
    sb_if.rd_en1 = 1'b1; sb_if.rd_a1 = 5'd0; sb_if.rd_tuse1 = 2'd0;
    sb_if.rd_en2 = 1'b1; sb_if.rd_a2 = 5'd0; sb_if.rd_tuse2 = 2'd0;
    #1; checks++;
    if (obs() !== 6'b000000) begin errors++; $display("FAIL reg0 got=%b exp=%b", obs(), 6'b000000); end
  endtask

  task automatic test_youngest();
    do_reset();
    sb_if.issue_valid = 1'b1; sb_if.issue_a3 = 5'd7; sb_if.issue_tnew = 2'd2;
    tick();
    sb_if.issue_tnew = 2'd0;
    tick();
    idle();
    sb_if.rd_en1 = 1'b1; sb_if.rd_a1 = 5'd7; sb_if.rd_tuse1 = 2'd0;
    sb_if.rd_en2 = 1'b1; sb_if.rd_a2 = 5'd7; sb_if.rd_tuse2 = 2'd0;
    #1; checks++;
    if (obs() !== 6'b001011) begin errors++; $display("FAIL youngest_e got=%b exp=%b", obs(), 6'b001011); end
    tick(); #1; checks++;
    if (obs() !== 6'b010101) begin errors++; $display("FAIL youngest_m got=%b exp=%b", obs(), 6'b010101); end
  endtask

  task automatic test_stall_blocks_issue();
    do_reset();
    sb_if.ext_stall = 1'b1;
    sb_if.issue_valid = 1'b1; sb_if.issue_a3 = 5'd9; sb_if.issue_tnew = 2'd1;
    sb_if.rd_a1 = 5'd9;
    #1; checks++;
    if (obs() !== 6'b100000) begin errors++; $display("FAIL ext_stall got=%b exp=%b", obs(), 6'b100000); end
    tick(); #1; checks++;
    if (obs() !== 6'b100000) begin errors++; $display("FAIL ext_stall_noissue got=%b exp=%b", obs(), 6'b100000); end
    sb_if.ext_stall = 1'b0;
    #1; checks++;
    if (obs() !== 6'b000000) begin errors++; $display("FAIL ext_release got=%b exp=%b", obs(), 6'b000000); end
    tick();
    sb_if.issue_valid = 1'b0;
    #1; checks++;
    if (obs() !== 6'b001001) begin errors++; $display("FAIL ext_issued got=%b exp=%b", obs(), 6'b001001); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    sb_if.issue_valid = 1'b1; sb_if.issue_a3 = 5'd4; sb_if.issue_tnew = 2'd2; tick();
    sb_if.issue_a3 = 5'd5; sb_if.issue_tnew = 2'd2; tick();
    sb_if.issue_a3 = 5'd6; sb_if.issue_tnew = 2'd1; tick();
    idle();
    sb_if.rd_en1 = 1'b1; sb_if.rd_a1 = 5'd4; sb_if.rd_tuse1 = 2'd0;
    sb_if.rd_en2 = 1'b1; sb_if.rd_a2 = 5'd5; sb_if.rd_tuse2 = 2'd0;
    #1; checks++;
    if (obs() !== 6'b111101) begin errors++; $display("FAIL midflight_pre got=%b exp=%b", obs(), 6'b111101); end
    reset = 1'b1;
    #1; checks++;
    if (obs() !== 6'b000000) begin errors++; $display("FAIL midflight_rst got=%b exp=%b", obs(), 6'b000000); end
    tick();
    reset = 1'b0; sb_if.rd_a2 = 5'd6;
    #1; checks++;
    if (obs() !== 6'b000000) begin errors++; $display("FAIL midflight_post got=%b exp=%b", obs(), 6'b000000); end
  endtask

  task automatic test_random();
    logic [5:0] exp_v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset             = ($urandom_range(0, 59) == 0);
      sb_if.issue_valid = 1'($urandom_range(0, 1));
      sb_if.issue_a3    = 5'($urandom_range(0, 7));
      sb_if.issue_tnew  = 2'($urandom_range(0, DEPTH - 1));
      sb_if.rd_en1      = 1'($urandom_range(0, 1));
      sb_if.rd_a1       = 5'($urandom_range(0, 7));
      sb_if.rd_tuse1    = 2'($urandom_range(0, 3));
      sb_if.rd_en2      = 1'($urandom_range(0, 1));
      sb_if.rd_a2       = 5'($urandom_range(0, 7));
      sb_if.rd_tuse2    = 2'($urandom_range(0, 3));
      sb_if.ext_stall   = ($urandom_range(0, 7) == 0);
      #1;
      exp_v = m_expect();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs(), exp_v);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    for (int s = 1; s <= DEPTH; s++) begin
      m_v[s] = 1'b0; m_r[s] = '0; m_t[s] = '0;
    end
    @(negedge clk);
    test_reset();
    test_load_use();
    test_alu_alu();
    test_reg0();
    test_youngest();
    test_stall_blocks_issue();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
